// File: rtl/instr_encoder.sv
// instr_encoder: packs register indices, funct codes and an immediate into
// an RV32I instruction word; expands LI into LUI+ADDI over two beats.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid / in_ready   request handshake
//   in_fmt                0=R 1=I 2=S 3=B 4=U 5=J 6=LI 7=reserved
//   in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm
//   out_valid / out_ready registered output handshake
//   out_instr, out_err    encoded word, range/format error flag
//
// Build option: define INSTR_ENC_RANGE_CHECK_EN to build the immediate
// range and reserved-format checks; otherwise out_err is tied to 0.

module instr_encoder #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2:0]      in_fmt,
   input  logic [6:0]      in_opcode,
   input  logic [4:0]      in_rd,
   input  logic [4:0]      in_rs1,
   input  logic [4:0]      in_rs2,
   input  logic [2:0]      in_funct3,
   input  logic [6:0]      in_funct7,
   input  logic [XLEN-1:0] in_imm,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_instr,
   output logic            out_err
);

   typedef enum logic {
      S_IDLE,
      S_SECOND
   } state_t;

   localparam logic [2:0] FMT_R  = 3'd0;
   localparam logic [2:0] FMT_I  = 3'd1;
   localparam logic [2:0] FMT_S  = 3'd2;
   localparam logic [2:0] FMT_B  = 3'd3;
   localparam logic [2:0] FMT_U  = 3'd4;
   localparam logic [2:0] FMT_J  = 3'd5;
   localparam logic [2:0] FMT_LI = 3'd6;

   localparam logic [6:0] OP_IMM = 7'h13;
   localparam logic [6:0] OP_LUI = 7'h37;

   state_t            r_state;
   logic              r_valid;
   logic [XLEN-1:0]   r_instr;
   logic              r_err;
   logic [XLEN-1:0]   r_second;

   logic              w_accept;
   logic [XLEN-1:0]   w_word;
   logic              w_err;
   logic              w_li_two;
   logic [XLEN-1:0]   w_li_add;
   logic              w_li_small;
   logic [XLEN-1:0]   w_second;

   assign in_ready  = rst_n && (r_state == S_IDLE)
                    && (!r_valid || out_ready);
   assign w_accept  = in_valid && in_ready;
   assign out_valid = r_valid;
   assign out_instr = r_instr;
   assign out_err   = r_err;

   // Rounding by 0x800 lets the sign-extended ADDI low part
   // cancel out against the LUI upper part.
   assign w_li_add   = in_imm + 32'h0000_0800;
   assign w_li_small = (in_imm[31:11] == {21{in_imm[11]}});
   assign w_second   = {in_imm[11:0], in_rd, 3'b000,
                        in_rd, OP_IMM};

   always_comb begin
      w_word   = '0;
      w_li_two = 1'b0;
      unique case (1'b1)
         (in_fmt == FMT_R):
            w_word = {in_funct7, in_rs2, in_rs1,
                      in_funct3, in_rd, in_opcode};
         (in_fmt == FMT_I):
            w_word = {in_imm[11:0], in_rs1,
                      in_funct3, in_rd, in_opcode};
         (in_fmt == FMT_S):
            w_word = {in_imm[11:5], in_rs2, in_rs1,
                      in_funct3, in_imm[4:0], in_opcode};
         (in_fmt == FMT_B):
            w_word = {in_imm[12], in_imm[10:5], in_rs2,
                      in_rs1, in_funct3, in_imm[4:1],
                      in_imm[11], in_opcode};
         (in_fmt == FMT_U):
            w_word = {in_imm[31:12], in_rd, in_opcode};
         (in_fmt == FMT_J):
            w_word = {in_imm[20], in_imm[10:1], in_imm[11],
                      in_imm[19:12], in_rd, in_opcode};
         (in_fmt == FMT_LI): begin
            if (w_li_small) begin
               w_word = {in_imm[11:0], 5'd0, 3'b000,
                         in_rd, OP_IMM};
            end else begin
               w_word   = {w_li_add[31:12], in_rd, OP_LUI};
               w_li_two = (in_imm[11:0] != 12'd0);
            end
         end
         default:
            w_word = '0;
      endcase
   end

`ifdef INSTR_ENC_RANGE_CHECK_EN
   logic w_fit12;
   logic w_fit13;
   logic w_fit21;

   // Signed-range tests: upper bits must be pure sign extension.
   assign w_fit12 = (in_imm[31:11] == {21{in_imm[11]}});
   assign w_fit13 = (in_imm[31:12] == {20{in_imm[12]}});
   assign w_fit21 = (in_imm[31:20] == {12{in_imm[20]}});

   always_comb begin
      w_err = 1'b0;
      unique case (1'b1)
         (in_fmt == FMT_I),
         (in_fmt == FMT_S):
            w_err = !w_fit12;
         (in_fmt == FMT_B):
            w_err = !w_fit13 || in_imm[0];
         (in_fmt == FMT_J):
            w_err = !w_fit21 || in_imm[0];
         (in_fmt == FMT_U):
            w_err = (in_imm[11:0] != 12'd0);
         (in_fmt == 3'd7):
            w_err = 1'b1;
         default:
            w_err = 1'b0;
      endcase
   end
`else
   assign w_err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_valid  <= 1'b0;
         r_instr  <= '0;
         r_err    <= 1'b0;
         r_second <= '0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_valid <= 1'b1;
                  r_instr <= w_word;
                  r_err   <= w_err;
                  if (w_li_two) begin
                     r_second <= w_second;
                     r_state  <= S_SECOND;
                  end
               end else if (out_ready) begin
                  r_valid <= 1'b0;
               end
            end
            S_SECOND: begin
               // LUI beat is held until taken, then ADDI follows.
               if (out_ready) begin
                  r_instr <= r_second;
                  r_err   <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed vector table for every format plus
// hand-written stall, LI two-beat and reset-in-SECOND sequences.

module tb_instr_encoder;

`ifdef INSTR_ENC_RANGE_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_fmt;
   logic [6:0]  in_opcode;
   logic [4:0]  in_rd;
   logic [4:0]  in_rs1;
   logic [4:0]  in_rs2;
   logic [2:0]  in_funct3;
   logic [6:0]  in_funct7;
   logic [31:0] in_imm;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic        out_err;

   int checks;
   int failures;

   instr_encoder #(.XLEN(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_fmt    (in_fmt),
      .in_opcode (in_opcode),
      .in_rd     (in_rd),
      .in_rs1    (in_rs1),
      .in_rs2    (in_rs2),
      .in_funct3 (in_funct3),
      .in_funct7 (in_funct7),
      .in_imm    (in_imm),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_instr (out_instr),
      .out_err   (out_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  fmt;
      logic [6:0]  op;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [31:0] imm;
      logic [31:0] exp_instr;
      logic        exp_err;
   } vec_t;

   vec_t vecs[15];

   task automatic check(input string name,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h",
                  name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      in_fmt    = v.fmt;
      in_opcode = v.op;
      in_rd     = v.rd;
      in_rs1    = v.rs1;
      in_rs2    = v.rs2;
      in_funct3 = v.f3;
      in_funct7 = v.f7;
      in_imm    = v.imm;
   endtask

   function automatic vec_t mk(input logic [2:0] fmt,
                               input logic [6:0] op,
                               input logic [4:0] rd,
                               input logic [4:0] rs1,
                               input logic [4:0] rs2,
                               input logic [2:0] f3,
                               input logic [6:0] f7,
                               input logic [31:0] imm,
                               input logic [31:0] ei,
                               input logic ee);
      vec_t v;
      v.fmt = fmt; v.op = op; v.rd = rd; v.rs1 = rs1;
      v.rs2 = rs2; v.f3 = f3; v.f7 = f7; v.imm = imm;
      v.exp_instr = ei; v.exp_err = ee;
      return v;
   endfunction

   // Waits for in_ready with in_valid held, then takes the edge.
   task automatic accept(input string name);
      int n;
      n = 0;
      while (!in_ready && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check({name, "_ready"}, {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   initial begin
      vec_t v;
      checks   = 0;
      failures = 0;

      vecs[0]  = mk(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0,
                    32'd5, 32'h0050_0093, 1'b0);
      vecs[1]  = mk(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0,
                    -32'sd4, 32'hFE00_0EE3, 1'b0);
      vecs[2]  = mk(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0,
                    -32'sd3, 32'hFE00_0EE3, 1'b1);
      vecs[3]  = mk(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0,
                    32'hDEAD_BEEF, 32'h0020_81B3, 1'b0);
      vecs[4]  = mk(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0,
                    32'h1234_5000, 32'h1234_52B7, 1'b0);
      vecs[5]  = mk(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0,
                    32'h1234_5001, 32'h1234_52B7, 1'b1);
      vecs[6]  = mk(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0,
                    32'd8, 32'h0080_00EF, 1'b0);
      vecs[7]  = mk(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0,
                    32'h0010_0000, 32'h8000_00EF, 1'b1);
      vecs[8]  = mk(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0,
                    32'd2048, 32'h8000_0093, 1'b1);
      vecs[9]  = mk(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0,
                    -32'sd2048, 32'h8000_0093, 1'b0);
      vecs[10] = mk(3'd7, 7'h13, 5'd1, 5'd2, 5'd3, 3'd1, 7'd1,
                    32'd1, 32'h0000_0000, 1'b1);
      vecs[11] = mk(3'd6, 7'h00, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0,
                    32'hFFFF_FFFF, 32'hFFF0_0293, 1'b0);
      vecs[12] = mk(3'd6, 7'h00, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0,
                    32'h0000_1000, 32'h0000_12B7, 1'b0);
      vecs[13] = mk(3'd2, 7'h23, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0,
                    -32'sd2049, 32'h7E00_0FA3, 1'b1);
      vecs[14] = mk(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0,
                    32'd4094, 32'h7E00_0FE3, 1'b0);

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      drive(vecs[0]);
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", {31'd0, out_valid}, 32'd0);
      check("rst_instr", out_instr, 32'd0);
      check("rst_err", {31'd0, out_err}, 32'd0);
      check("rst_in_ready", {31'd0, in_ready}, 32'd0);
      rst_n = 1'b1;
      #1;
      check("idle_in_ready", {31'd0, in_ready}, 32'd1);

      // Back-to-back stream: one word per cycle.
      for (int i = 0; i < 15; i++) begin
         drive(vecs[i]);
         in_valid = 1'b1;
         #1;
         check($sformatf("v%0d_ready", i),
               {31'd0, in_ready}, 32'd1);
         @(posedge clk); #1;
         check($sformatf("v%0d_valid", i),
               {31'd0, out_valid}, 32'd1);
         check($sformatf("v%0d_instr", i),
               out_instr, vecs[i].exp_instr);
         check($sformatf("v%0d_err", i), {31'd0, out_err},
               {31'd0, vecs[i].exp_err & CHK});
      end
      in_valid = 1'b0;
      @(posedge clk); #1;
      check("drain_valid", {31'd0, out_valid}, 32'd0);

      // Output stall holds S word and blocks input.
      v = mk(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0,
             32'd8, 32'h0020_A423, 1'b0);
      drive(v);
      in_valid = 1'b1;
      accept("s");
      out_ready = 1'b0;
      in_valid  = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1;
         check($sformatf("stall%0d_instr", k),
               out_instr, 32'h0020_A423);
         check($sformatf("stall%0d_valid", k),
               {31'd0, out_valid}, 32'd1);
         check($sformatf("stall%0d_in_ready", k),
               {31'd0, in_ready}, 32'd0);
         @(posedge clk); #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      #1;
      check("stall_release_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
      check("stall_drained", {31'd0, out_valid}, 32'd0);

      // LI two beats with toggling out_ready.
      v = mk(3'd6, 7'h00, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0,
             32'h1234_5FFF, 32'h0, 1'b0);
      drive(v);
      in_valid = 1'b1;
      accept("li");
      check("li_lui", out_instr, 32'h1234_62B7);
      check("li_lui_err", {31'd0, out_err}, 32'd0);
      check("li_lui_in_ready", {31'd0, in_ready}, 32'd0);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      @(posedge clk); #1;
      check("li_lui_hold", out_instr, 32'h1234_62B7);
      out_ready = 1'b1;
      #1;
      check("li_second_in_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("li_addi", out_instr, 32'hFFF2_8293);
      check("li_addi_valid", {31'd0, out_valid}, 32'd1);
      check("li_addi_err", {31'd0, out_err}, 32'd0);
      out_ready = 1'b0;
      #1;
      check("li_addi_hold_ready", {31'd0, in_ready}, 32'd0);
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("li_drained", {31'd0, out_valid}, 32'd0);

      // Reset while in SECOND drops the pending ADDI.
      drive(v);
      in_valid = 1'b1;
      accept("li_rst");
      check("li_rst_lui", out_instr, 32'h1234_62B7);
      rst_n = 1'b0;
      @(posedge clk); #1;
      check("midrst_valid", {31'd0, out_valid}, 32'd0);
      check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
      rst_n = 1'b1;
      #1;
      check("midrst_idle", {31'd0, in_ready}, 32'd1);
      drive(vecs[8]);
      in_valid = 1'b1;
      accept("post_rst");
      check("post_rst_instr", out_instr, 32'h8000_0093);
      check("post_rst_err", {31'd0, out_err}, {31'd0, CHK});
      @(posedge clk); #1;
      check("post_rst_no_addi", {31'd0, out_valid}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d",
               checks, failures);
      $finish;
   end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Inverse of the core's immediate generator: packs register indices, function codes and a 32-bit immediate into a legal RV32I instruction word.
- Used by the self-test sequencer and boot-ROM patch logic to build instructions on chip.
- Valid/ready input and registered valid/ready output.
- Expands the LI pseudo-instruction into a LUI+ADDI pair over two output beats.

Parameters:
- XLEN, 32, instruction/immediate width; only 32 is supported.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  reset, synchronous, active-low
- in_valid  input  1  request valid
- in_ready  output  1  request accepted when in_valid && in_ready
- in_fmt  input  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 6=LI, 7=reserved
- in_opcode  input  7  opcode[6:0]; ignored for LI
- in_rd  input  5  destination register
- in_rs1  input  5  source register 1
- in_rs2  input  5  source register 2
- in_funct3  input  3  funct3
- in_funct7  input  7  funct7; R only
- in_imm  input  32  immediate, two's complement, unencoded
- out_valid  output  1  instruction word valid
- out_ready  input  1  consumer accepts when out_valid && out_ready
- out_instr  output  32  encoded instruction
- out_err  output  1  immediate out of range or reserved format; qualified by out_valid

Behaviour:
- Clock is clk. Reset is rst_n, synchronous and active-low.
- Reset values: out_valid=0, out_instr=0, out_err=0, FSM=IDLE. in_ready is 0 while rst_n=0.
- Reset mid-operation:
  - Discards any held word.
  - Discards any pending second LI beat.
- Handshake:
  - in_ready = (state==IDLE) && (!out_valid || out_ready). The block is a combinational function of registered state.
  - Latency is 1 cycle from accept to out_valid.
  - Full throughput of 1 word/cycle for non-LI formats.
  - While out_valid && !out_ready, out_instr and out_err hold stable.
- Field packing (bits not listed come from request fields):
  - R: funct7[31:25], rs2[24:20], rs1[19:15], funct3[14:12], rd[11:7], opcode[6:0]. Immediate is ignored.
  - I: imm[11:0]→[31:20].
  - S: imm[11:5]→[31:25], imm[4:0]→[11:7].
  - B: imm[12]→[31], imm[10:5]→[30:25], imm[4:1]→[11:8], imm[11]→[7].
  - U: imm[31:12]→[31:12].
  - J: imm[20]→[31], imm[10:1]→[30:21], imm[11]→[20], imm[19:12]→[19:12].
- Range errors (out_err=1; word is still emitted with truncated fields):
  - I/S: imm outside −2048..2047.
  - B: imm outside −4096..4094, or imm[0]=1.
  - J: imm outside −2^20..2^20−2, or imm[0]=1.
  - U: imm[11:0]≠0.
  - fmt=7: out_instr=0, out_err=1.
- LI FSM, states IDLE and SECOND:
  - If imm is within −2048..2047: emit ADDI rd,x0,imm (opcode 0x13, funct3 0) as a single beat.
  - Otherwise compute lo=imm[11:0] and hi=(imm+0x800)[31:12], ignoring carry-out.
    - Emit LUI rd,hi (opcode 0x37).
    - If lo≠0, go to SECOND. On handshake of the LUI beat, emit ADDI rd,rd,lo and return to IDLE.
  - If lo==0, only the LUI beat is emitted.
  - in_ready=0 throughout SECOND.
  - LI never sets out_err.
- Simultaneous output handshake and new accept in the same cycle: the new word replaces the old one with no bubble.

Optional Feature:
- Macro: INSTR_ENC_RANGE_CHECK_EN.
- Defined: range and reserved-format checks as above.
- Undefined:
  - No check logic is built; out_err is tied to 0.
  - fmt=7 still yields out_instr=0.

Test Plan:
- I, opcode 0x13, rd=1, rs1=0, funct3=0, imm=5 -> next cycle out_valid=1, out_instr=0x00500093, out_err=0.
- S, opcode 0x23, funct3=2, rs1=1, rs2=2, imm=8 with out_ready=0 for 3 cycles -> out_instr=0x0020A423 held stable; in_ready=0 until accepted.
- B, opcode 0x63, rs1=rs2=0, funct3=0, imm=−4 -> 0xFE000EE3. Repeat with imm=−3 -> out_err=1.
- LI rd=5, imm=0x12345FFF with out_ready toggling -> beats 0x123462B7 then 0xFFF28293; in_ready=0 until the second beat is accepted.
- LI rd=5, imm=0x00001000 -> single beat 0x000012B7. LI imm=−1 -> single beat 0xFFF00293.
- Assert rst_n=0 while in SECOND -> next cycle out_valid=0, state IDLE. After release, I imm=2048 -> 0x80000093 with out_err=1 (macro defined) or 0 (undefined).
